data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU memory stage and the NPU.
// Optional access watchdog enabled by defining DMEM_TIMEOUT_EN (TIMEOUT_CYCLES sets the limit).
//   state   | meaning
//   IDLE    | no owner, arbitrate incoming requests
//   GNT_CPU | CPU request driven on memory port, waiting for ready
//   GNT_NPU | NPU request driven on memory port, waiting for ready
//   DONE    | one-cycle completion pulse to the owner
module data_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iCpuValid,
  input  logic        iCpuRW,
  input  logic [31:0] iCpuAddr,
  input  logic [31:0] iCpuData,
  output logic        oCpuReady,
  output logic [31:0] oCpuData,
  input  logic        iNpuValid,
  input  logic        iNpuRW,
  input  logic [31:0] iNpuAddr,
  input  logic [31:0] iNpuData,
  output logic        oNpuReady,
  output logic [31:0] oNpuData,
  output logic        oMemValid,
  output logic        oMemRW,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemData,
  input  logic        iMemReady,
  input  logic [31:0] iMemData,
  output logic [1:0]  oGrant,
  output logic        oTimeout
);

  typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_NPU, DONE} state_t;

  state_t      state, state_nx;
  logic        last_npu, last_npu_nx;
  logic        mem_valid, mem_valid_nx, mem_rw, mem_rw_nx;
  logic [31:0] mem_addr, mem_addr_nx, mem_data, mem_data_nx;
  logic        cpu_ready, cpu_ready_nx, npu_ready, npu_ready_nx;
  logic [31:0] cpu_data, cpu_data_nx, npu_data, npu_data_nx;
  logic [1:0]  grant, grant_nx;
  logic        timeout, timeout_nx;
  logic        finish;
  logic [31:0] fin_data;
  logic        pick_cpu;

`ifdef DMEM_TIMEOUT_EN
  logic [7:0]  wait_cnt, wait_cnt_nx;
`else
  logic [7:0]  unused_timeout;
  assign unused_timeout = 8'(TIMEOUT_CYCLES);
`endif

  // On a tie, the requester that did not win last time gets the port.
  assign pick_cpu = iCpuValid && (!iNpuValid || last_npu);

  always_comb begin
    state_nx     = state;
    last_npu_nx  = last_npu;
    mem_valid_nx = mem_valid;
    mem_rw_nx    = mem_rw;
    mem_addr_nx  = mem_addr;
    mem_data_nx  = mem_data;
    cpu_ready_nx = 1'b0;
    npu_ready_nx = 1'b0;
    cpu_data_nx  = cpu_data;
    npu_data_nx  = npu_data;
    grant_nx     = grant;
    timeout_nx   = 1'b0;
    finish       = 1'b0;
    fin_data     = '0;
`ifdef DMEM_TIMEOUT_EN
    wait_cnt_nx  = wait_cnt;
`endif
    case (state)
      IDLE: begin
        grant_nx     = 2'b00;
        mem_valid_nx = 1'b0;
        if (pick_cpu) begin
          state_nx     = GNT_CPU;
          last_npu_nx  = 1'b0;
          grant_nx     = 2'b01;
          mem_valid_nx = 1'b1;
          mem_rw_nx    = iCpuRW;
          mem_addr_nx  = iCpuAddr;
          mem_data_nx  = iCpuData;
`ifdef DMEM_TIMEOUT_EN
          wait_cnt_nx  = '0;
`endif
        end else if (iNpuValid) begin
          state_nx     = GNT_NPU;
          last_npu_nx  = 1'b1;
          grant_nx     = 2'b10;
          mem_valid_nx = 1'b1;
          mem_rw_nx    = iNpuRW;
          mem_addr_nx  = iNpuAddr;
          mem_data_nx  = iNpuData;
`ifdef DMEM_TIMEOUT_EN
          wait_cnt_nx  = '0;
`endif
        end
      end
      GNT_CPU, GNT_NPU: begin
        if (iMemReady) begin
          finish   = 1'b1;
          fin_data = mem_rw ? 32'h0 : iMemData;
        end
`ifdef DMEM_TIMEOUT_EN
        else begin
          // A ready on the terminal-count cycle still completes normally.
          wait_cnt_nx = wait_cnt + 8'd1;
          if (wait_cnt_nx == 8'(TIMEOUT_CYCLES)) begin
            finish     = 1'b1;
            timeout_nx = 1'b1;
          end
        end
`endif
        if (finish) begin
          state_nx     = DONE;
          mem_valid_nx = 1'b0;
          if (state == GNT_CPU) begin
            cpu_ready_nx = 1'b1;
            cpu_data_nx  = fin_data;
          end else begin
            npu_ready_nx = 1'b1;
            npu_data_nx  = fin_data;
          end
        end
      end
      DONE: begin
        state_nx     = IDLE;
        grant_nx     = 2'b00;
        mem_valid_nx = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state     <= IDLE;
      last_npu  <= 1'b1;
      mem_valid <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      cpu_ready <= 1'b0;
      npu_ready <= 1'b0;
      cpu_data  <= '0;
      npu_data  <= '0;
      grant     <= 2'b00;
      timeout   <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      state     <= state_nx;
      last_npu  <= last_npu_nx;
      mem_valid <= mem_valid_nx;
      mem_rw    <= mem_rw_nx;
      mem_addr  <= mem_addr_nx;
      mem_data  <= mem_data_nx;
      cpu_ready <= cpu_ready_nx;
      npu_ready <= npu_ready_nx;
      cpu_data  <= cpu_data_nx;
      npu_data  <= npu_data_nx;
      grant     <= grant_nx;
      timeout   <= timeout_nx;
`ifdef DMEM_TIMEOUT_EN
      wait_cnt  <= wait_cnt_nx;
`endif
    end
  end

  assign oCpuReady = cpu_ready;
  assign oCpuData  = cpu_data;
  assign oNpuReady = npu_ready;
  assign oNpuData  = npu_data;
  assign oMemValid = mem_valid;
  assign oMemRW    = mem_rw;
  assign oMemAddr  = mem_addr;
  assign oMemData  = mem_data;
  assign oGrant    = grant;
  assign oTimeout  = timeout;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed accesses push expected completions,
// a negedge monitor pops and compares them whenever a ready pulse appears.
module tb_data_mem_arbiter;

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic        iCpuValid = 1'b0, iCpuRW = 1'b0;
  logic [31:0] iCpuAddr = '0, iCpuData = '0;
  logic        oCpuReady;
  logic [31:0] oCpuData;
  logic        iNpuValid = 1'b0, iNpuRW = 1'b0;
  logic [31:0] iNpuAddr = '0, iNpuData = '0;
  logic        oNpuReady;
  logic [31:0] oNpuData;
  logic        oMemValid, oMemRW;
  logic [31:0] oMemAddr, oMemData;
  logic        iMemReady = 1'b0;
  logic [31:0] iMemData = '0;
  logic [1:0]  oGrant;
  logic        oTimeout;

  data_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .iClk(iClk), .iRst_n(iRst_n),
    .iCpuValid(iCpuValid), .iCpuRW(iCpuRW), .iCpuAddr(iCpuAddr), .iCpuData(iCpuData),
    .oCpuReady(oCpuReady), .oCpuData(oCpuData),
    .iNpuValid(iNpuValid), .iNpuRW(iNpuRW), .iNpuAddr(iNpuAddr), .iNpuData(iNpuData),
    .oNpuReady(oNpuReady), .oNpuData(oNpuData),
    .oMemValid(oMemValid), .oMemRW(oMemRW), .oMemAddr(oMemAddr), .oMemData(oMemData),
    .iMemReady(iMemReady), .iMemData(iMemData),
    .oGrant(oGrant), .oTimeout(oTimeout)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    bit          is_cpu;
    logic [31:0] data;
    logic [1:0]  grant;
    bit          tmo;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic start_cpu(input logic rw, input logic [31:0] a, input logic [31:0] d);
    iCpuValid = 1'b1; iCpuRW = rw; iCpuAddr = a; iCpuData = d;
  endtask

  task automatic start_npu(input logic rw, input logic [31:0] a, input logic [31:0] d);
    iNpuValid = 1'b1; iNpuRW = rw; iNpuAddr = a; iNpuData = d;
  endtask

  // Entered #1 after the grant edge; leaves #1 after the DONE->IDLE edge.
  task automatic serve(input bit is_cpu, input int delay, input logic [31:0] rdata);
    logic [31:0] ea, ed;
    logic        er;
    exp_t        e;
    ea = is_cpu ? iCpuAddr : iNpuAddr;
    ed = is_cpu ? iCpuData : iNpuData;
    er = is_cpu ? iCpuRW : iNpuRW;
    check("grant_owner", 32'(oGrant), is_cpu ? 32'd1 : 32'd2);
    check("mem_valid", 32'(oMemValid), 32'd1);
    check("mem_rw", 32'(oMemRW), 32'(er));
    check("mem_addr", oMemAddr, ea);
    check("mem_data", oMemData, ed);
    for (int i = 0; i < delay; i++) begin
      tick();
      check("hold_valid", 32'(oMemValid), 32'd1);
      check("hold_addr", oMemAddr, ea);
      check("hold_data", oMemData, ed);
      check("hold_no_ready", 32'({oNpuReady, oCpuReady}), 32'd0);
    end
    iMemReady = 1'b1;
    iMemData  = rdata;
    e.is_cpu = is_cpu;
    e.data   = er ? 32'h0 : rdata;
    e.grant  = is_cpu ? 2'b01 : 2'b10;
    e.tmo    = 1'b0;
    sb.push_back(e);
    tick();
    iMemReady = 1'b0;
    iMemData  = 32'hDEAD_BEEF;
    check("latency_ready", 32'(is_cpu ? oCpuReady : oNpuReady), 32'd1);
    if (is_cpu) iCpuValid = 1'b0;
    else        iNpuValid = 1'b0;
    tick();
    check("single_pulse", 32'({oNpuReady, oCpuReady}), 32'd0);
    check("idle_grant", 32'(oGrant), 32'd0);
    check("data_hold", is_cpu ? oCpuData : oNpuData, e.data);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_valid"}, 32'(oMemValid), 32'd0);
    check({tag, "_mem_rw"}, 32'(oMemRW), 32'd0);
    check({tag, "_mem_addr"}, oMemAddr, 32'd0);
    check({tag, "_mem_data"}, oMemData, 32'd0);
    check({tag, "_ready"}, 32'({oNpuReady, oCpuReady}), 32'd0);
    check({tag, "_cpu_data"}, oCpuData, 32'd0);
    check({tag, "_npu_data"}, oNpuData, 32'd0);
    check({tag, "_grant"}, 32'(oGrant), 32'd0);
    check({tag, "_timeout"}, 32'(oTimeout), 32'd0);
  endtask

  always @(negedge iClk) begin
    if (oCpuReady || oNpuReady) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_ready: cpu=%0b npu=%0b with nothing pending", oCpuReady, oNpuReady);
      end else begin
        mon_e = sb.pop_front();
        check("ready_owner", 32'({oNpuReady, oCpuReady}), mon_e.is_cpu ? 32'd1 : 32'd2);
        check("ready_data", mon_e.is_cpu ? oCpuData : oNpuData, mon_e.data);
        check("ready_grant", 32'(oGrant), 32'(mon_e.grant));
        check("ready_timeout", 32'(oTimeout), 32'(mon_e.tmo));
        check("ready_mem_valid", 32'(oMemValid), 32'd0);
      end
    end else if (oTimeout) begin
      vectors++;
      miscompares++;
      $display("FAIL stray_timeout: got 1 expected 0");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick();
    tick();
    check_reset_outputs("reset");
    iRst_n = 1'b1;
    tick();

    // single CPU read, memory ready in the first valid cycle
    start_cpu(1'b0, 32'h0000_0100, 32'h0);
    tick();
    serve(1'b1, 0, 32'hCAFE_0001);

    // NPU write with delayed ready, then NPU read
    start_npu(1'b1, 32'h0000_2000, 32'h1234_5678);
    tick();
    serve(1'b0, 5, 32'hFFFF_0000);
    start_npu(1'b0, 32'h0000_2004, 32'h0);
    tick();
    serve(1'b0, 1, 32'h0BAD_F00D);

    // CPU write returns zero data and leaves CPU as last owner
    start_cpu(1'b1, 32'h0000_0300, 32'hA5A5_A5A5);
    tick();
    serve(1'b1, 2, 32'h1111_2222);

    // tie with CPU last granted: NPU first
    start_cpu(1'b0, 32'h0000_0400, 32'h0);
    start_npu(1'b0, 32'h0000_0500, 32'h0);
    tick();
    serve(1'b0, 0, 32'h0000_0005);
    tick();
    serve(1'b1, 0, 32'h0000_0004);

    // tie right after reset: CPU, then NPU, then CPU wins the next tie
    iRst_n = 1'b0;
    tick();
    iRst_n = 1'b1;
    start_cpu(1'b0, 32'h0000_0410, 32'h0);
    start_npu(1'b0, 32'h0000_0510, 32'h0);
    tick();
    serve(1'b1, 0, 32'hC0C0_0001);
    tick();
    serve(1'b0, 1, 32'hA0A0_0002);
    start_cpu(1'b0, 32'h0000_0420, 32'h0);
    start_npu(1'b0, 32'h0000_0520, 32'h0);
    tick();
    serve(1'b1, 0, 32'hC0C0_0003);
    tick();
    serve(1'b0, 0, 32'hA0A0_0004);

    // spurious memory ready while idle
    iMemReady = 1'b1;
    iMemData  = 32'h5555_AAAA;
    tick();
    tick();
    check("spurious_mem_valid", 32'(oMemValid), 32'd0);
    check("spurious_grant", 32'(oGrant), 32'd0);
    check("spurious_cpu_data", oCpuData, 32'hC0C0_0003);
    iMemReady = 1'b0;
    tick();

    // reset during GNT_CPU, memory ready arriving afterwards
    start_cpu(1'b0, 32'h0000_0600, 32'h0);
    tick();
    check("pre_reset_valid", 32'(oMemValid), 32'd1);
    iRst_n    = 1'b0;
    iCpuValid = 1'b0;
    tick();
    iRst_n    = 1'b1;
    iMemReady = 1'b1;
    iMemData  = 32'h6666_6666;
    check_reset_outputs("midreset");
    tick();
    iMemReady = 1'b0;
    check_reset_outputs("after_reset");
    tick();

    // watchdog behaviour
    start_cpu(1'b0, 32'h0000_0700, 32'h0);
    tick();
`ifdef DMEM_TIMEOUT_EN
    mon_e.is_cpu = 1'b1;
    mon_e.data   = 32'h0;
    mon_e.grant  = 2'b01;
    mon_e.tmo    = 1'b1;
    sb.push_back(mon_e);
    repeat (4) tick();
    check("timeout_ready", 32'(oCpuReady), 32'd1);
    check("timeout_pulse", 32'(oTimeout), 32'd1);
    iCpuValid = 1'b0;
    tick();
    check("timeout_clear", 32'(oTimeout), 32'd0);
`else
    repeat (20) tick();
    check("no_timeout_valid", 32'(oMemValid), 32'd1);
    check("no_timeout_grant", 32'(oGrant), 32'd1);
    serve(1'b1, 0, 32'h7777_0007);
`endif

    repeat (3) tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
